gpio_bank_ctrl: RTL and testbench

//  CPU-facing controller for a bank of WIDTH single-bit GPIO cells on the 6502 bus.

---
 rtl/gpio_bank_ctrl_if.sv | 11 +
 rtl/gpio_bank_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_gpio_bank_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bank_ctrl_if.sv
// CPU-side register bus of the GPIO bank controller (6502-style read/write port plus irq).
interface gpio_bank_ctrl_if;
  logic [2:0] addr;
  logic       we;
  logic [7:0] di;
  logic [7:0] rdata;
  logic       irq;

  modport master (output addr, we, di, input rdata, irq);
  modport slave  (input addr, we, di, output rdata, irq);
endinterface

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank controller: data/direction registers, pin-readback synchroniser,
// edge-triggered interrupt flags and a power-up sequencer that pushes 0 into the cells.
module gpio_bank_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_bank_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] gpio_dir,
  output logic [WIDTH-1:0] gpio_dout,
  output logic [WIDTH-1:0] gpio_we,
  input  logic [WIDTH-1:0] gpio_din
);

  localparam int unsigned CNT_W = 2;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_DDR   = 3'd1;
  localparam logic [2:0] ADDR_RISE  = 3'd2;
  localparam logic [2:0] ADDR_FALL  = 3'd3;
  localparam logic [2:0] ADDR_IFLAG = 3'd4;
  localparam logic [2:0] ADDR_OLAT  = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] ddr_q, ddr_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] iflag_q, iflag_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] we_q, we_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] cur_c;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] clr_c;
  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] fall_c;

  // Pin synchroniser: the cell already registers once, so zero stages is a pass-through.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign cur_c = gpio_din;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];
      logic [WIDTH-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = gpio_din;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_d[i];
          end
        end
      end

      assign cur_c = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Next-state, register-write, edge-flag and read-mux logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ddr_d   = ddr_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    we_d    = '0;
    prev_d  = cur_c;
    irq_d   = |iflag_q;
    rdata_d = 8'h00;
    clr_c   = '0;
    wdata_c = bus.di[WIDTH-1:0];
    rise_c  =  cur_c & ~prev_q & rise_q & ~ddr_q;
    fall_c  = ~cur_c &  prev_q & fall_q & ~ddr_q;

    unique case (state_q)
      ST_INIT: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
        we_d    = '1;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SYNC_STAGES)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (bus.we) begin
      case (bus.addr)
        ADDR_DATA: begin
          data_d = wdata_c;
          we_d   = '1;
        end
        ADDR_DDR:   ddr_d  = wdata_c;
        ADDR_RISE:  rise_d = wdata_c;
        ADDR_FALL:  fall_d = wdata_c;
        ADDR_IFLAG: clr_c  = wdata_c;
        default:    ;
      endcase
    end

    // A newly detected edge wins over a same-cycle write-1-clear.
    iflag_d = iflag_q & ~clr_c;
    if (state_q == ST_RUN) begin
      iflag_d = iflag_d | rise_c | fall_c;
    end

    case (bus.addr)
      ADDR_DATA:  rdata_d = 8'(cur_c);
      ADDR_DDR:   rdata_d = 8'(ddr_q);
      ADDR_RISE:  rdata_d = 8'(rise_q);
      ADDR_FALL:  rdata_d = 8'(fall_q);
      ADDR_IFLAG: rdata_d = 8'(iflag_q);
      ADDR_OLAT:  rdata_d = 8'(data_q);
      default:    rdata_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      data_q  <= '0;
      ddr_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      iflag_q <= '0;
      prev_q  <= '0;
      we_q    <= '0;
      rdata_q <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ddr_q   <= ddr_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      iflag_q <= iflag_d;
      prev_q  <= prev_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign gpio_dir  = ddr_q;
  assign gpio_dout = data_q;
  assign gpio_we   = we_q;
  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Self-checking bench for gpio_bank_ctrl: stimulus pushes expected per-cycle outputs
// computed from a pin-history reference model; a monitor pops and compares them.
module tb_gpio_bank_ctrl;
  localparam int unsigned WIDTH       = 8;
  localparam int unsigned SYNC_STAGES = 1;
  localparam logic [7:0]  MASK        = 8'((9'h1 << WIDTH) - 9'h1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] gpio_dir, gpio_dout, gpio_we, gpio_din;

  gpio_bank_ctrl_if bus ();

  gpio_bank_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .gpio_dir  (gpio_dir),
    .gpio_dout (gpio_dout),
    .gpio_we   (gpio_we),
    .gpio_din  (gpio_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rd;
    logic       irq;
    logic [7:0] we;
    logic [7:0] dir;
    logic [7:0] dout;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;

  // Reference model state: architectural registers plus history of driven pins.
  logic [7:0] m_data, m_ddr, m_rise, m_fall, m_iflag;
  logic [7:0] hist[$];
  int         n_edges;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_ddr   = 8'h00;
    m_rise  = 8'h00;
    m_fall  = 8'h00;
    m_iflag = 8'h00;
    hist.delete();
    n_edges = 0;
  endtask

  // One bus cycle: drive on negedge, then model what the DUT shows after the next posedge.
  task automatic step(input logic w, input logic [2:0] a, input logic [7:0] d,
                      input logic [7:0] pins);
    exp_t       e;
    logic [7:0] cur, prev, nf;
    bit         run;
    @(negedge clk);
    bus.we   = w;
    bus.addr = a;
    bus.di   = d;
    gpio_din = pins[WIDTH-1:0];
    @(posedge clk);
    hist.push_front(pins & MASK);
    if (hist.size() > 8) void'(hist.pop_back());
    n_edges++;
    // Pin value seen by the edge logic is the one driven SYNC_STAGES edges ago.
    cur  = (hist.size() > int'(SYNC_STAGES))     ? hist[SYNC_STAGES]     : 8'h00;
    prev = (hist.size() > int'(SYNC_STAGES) + 1) ? hist[SYNC_STAGES + 1] : 8'h00;
    run  = (n_edges >= int'(SYNC_STAGES) + 3);

    case (a)
      3'd0:    e.rd = cur;
      3'd1:    e.rd = m_ddr;
      3'd2:    e.rd = m_rise;
      3'd3:    e.rd = m_fall;
      3'd4:    e.rd = m_iflag;
      3'd5:    e.rd = m_data;
      default: e.rd = 8'h00;
    endcase
    e.irq = (m_iflag != 8'h00);

    nf = m_iflag;
    if (w && a == 3'd4) nf = nf & ~(d & MASK);
    if (run) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (!m_ddr[i]) begin
          if (cur[i] && !prev[i] && m_rise[i]) nf[i] = 1'b1;
          if (!cur[i] && prev[i] && m_fall[i]) nf[i] = 1'b1;
        end
      end
    end
    m_iflag = nf;

    e.we = (n_edges == 1) ? MASK : 8'h00;
    if (w) begin
      case (a)
        3'd0: begin m_data = d & MASK; e.we = MASK; end
        3'd1: m_ddr  = d & MASK;
        3'd2: m_rise = d & MASK;
        3'd3: m_fall = d & MASK;
        default: ;
      endcase
    end
    e.dir  = m_ddr;
    e.dout = m_data;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rdata", bus.rdata, e.rd);
        chk("irq", 8'(bus.irq), 8'(e.irq));
        chk("gpio_we", 8'(gpio_we), e.we);
        chk("gpio_dir", 8'(gpio_dir), e.dir);
        chk("gpio_dout", 8'(gpio_dout), e.dout);
      end
    end
  end

  initial begin
    logic [7:0] pins;
    reset_n  = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 3'd0;
    bus.di   = 8'h00;
    gpio_din = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_irq", 8'(bus.irq), 8'h00);
    chk("rst_we", 8'(gpio_we), 8'h00);
    chk("rst_dir", 8'(gpio_dir), 8'h00);
    chk("rst_dout", 8'(gpio_dout), 8'h00);
    reset_n = 1'b1;

    // Power-up pulse and quiet settle with all pins high.
    repeat (SYNC_STAGES + 5) step(1'b0, 3'd4, 8'h00, 8'hFF);

    // Direction and data writes, latch readback.
    step(1'b1, 3'd1, 8'h0F, 8'hFF);
    step(1'b1, 3'd0, 8'hA5, 8'hFF);
    step(1'b0, 3'd5, 8'h00, 8'hFF);
    step(1'b0, 3'd0, 8'h00, 8'hFF);

    // Rising edge on bit 4, IFLAG read repeatedly without side effects.
    step(1'b1, 3'd2, 8'h10, 8'h00);
    repeat (SYNC_STAGES + 3) step(1'b0, 3'd4, 8'h00, 8'h00);
    repeat (SYNC_STAGES + 4) step(1'b0, 3'd4, 8'h00, 8'h10);

    // Clear coinciding with a new rise on the same bit: set wins.
    repeat (SYNC_STAGES + 2) step(1'b0, 3'd4, 8'h00, 8'h00);
    if (SYNC_STAGES == 0) begin
      step(1'b1, 3'd4, 8'h10, 8'h10);
    end else begin
      step(1'b0, 3'd4, 8'h00, 8'h10);
      repeat (SYNC_STAGES - 1) step(1'b0, 3'd4, 8'h00, 8'h10);
      step(1'b1, 3'd4, 8'h10, 8'h10);
    end
    repeat (3) step(1'b0, 3'd4, 8'h00, 8'h10);
    step(1'b1, 3'd4, 8'h10, 8'h10);
    repeat (3) step(1'b0, 3'd4, 8'h00, 8'h10);

    // Output pins never flag; switching to input does not flag; later falls do.
    step(1'b1, 3'd2, 8'h00, 8'h00);
    step(1'b1, 3'd1, 8'h01, 8'h00);
    step(1'b1, 3'd3, 8'h01, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 3'd4, 8'h00, (i % 2 == 0) ? 8'h01 : 8'h00);
    repeat (SYNC_STAGES + 2) step(1'b0, 3'd4, 8'h00, 8'h01);
    step(1'b1, 3'd1, 8'h00, 8'h01);
    repeat (SYNC_STAGES + 3) step(1'b0, 3'd4, 8'h00, 8'h01);
    repeat (SYNC_STAGES + 3) step(1'b0, 3'd4, 8'h00, 8'h00);
    step(1'b1, 3'd4, 8'hFF, 8'h00);

    // Randomised traffic against the model.
    pins = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) pins = 8'($urandom);
      step(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 8'($urandom), pins);
    end

    // Set every flag, then assert reset during a gpio_we pulse.
    step(1'b1, 3'd1, 8'h00, 8'h00);
    step(1'b1, 3'd2, 8'hFF, 8'h00);
    step(1'b1, 3'd4, 8'hFF, 8'h00);
    repeat (SYNC_STAGES + 2) step(1'b0, 3'd4, 8'h00, 8'h00);
    repeat (SYNC_STAGES + 2) step(1'b0, 3'd4, 8'h00, 8'hFF);
    step(1'b1, 3'd0, 8'h3C, 8'hFF);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_rdata", bus.rdata, 8'h00);
    chk("arst_irq", 8'(bus.irq), 8'h00);
    chk("arst_we", 8'(gpio_we), 8'h00);
    chk("arst_dir", 8'(gpio_dir), 8'h00);
    chk("arst_dout", 8'(gpio_dout), 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (SYNC_STAGES + 4) step(1'b0, 3'd4, 8'h00, 8'hFF);

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", 8'(sb_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
